// File: rtl/ram_thrash.sv
// Block-RAM power load: fills the RAM from the generator buses, then keeps writing and reading it.
// Read words fold into a rotating-XOR signature. Define RAM_THRASH_DUAL_ISSUE_EN to write and read on every RUN cycle.
module ram_thrash #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [15:0]           dummy_address,
    input  logic [15:0]           dummy_data,
    output logic                  fill_done,
    output logic [DATA_WIDTH-1:0] signature,
    output logic                  dummy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {FILL, RUN} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_fillPtr;
    logic                  r_phase;
    logic                  r_rdPend;
    logic [ADDR_WIDTH-1:0] r_rdAddr;
    logic                  r_rdValid;
    logic [DATA_WIDTH-1:0] r_rdData;
    logic                  r_fillDone;
    logic [DATA_WIDTH-1:0] r_signature;
    logic                  r_dummy;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_wrEn;
    logic [ADDR_WIDTH-1:0] w_wrAddr;
    logic                  w_rdIssue;
    logic [ADDR_WIDTH-1:0] w_rdAddr;
    logic                  w_unused;

    assign w_addr   = dummy_address[ADDR_WIDTH-1:0];
    assign w_data   = dummy_data[DATA_WIDTH-1:0];
    assign w_unused = ^{dummy_address, dummy_data, r_phase};

    // Decode which RAM accesses this cycle issues; nothing is issued while held in reset.
    always_comb begin
        w_wrEn    = 1'b0;
        w_wrAddr  = w_addr;
        w_rdIssue = 1'b0;
        w_rdAddr  = w_addr;
        if (!reset && enable) begin
            if (r_state == FILL) begin
                w_wrEn   = 1'b1;
                w_wrAddr = r_fillPtr;
            end else begin
`ifdef RAM_THRASH_DUAL_ISSUE_EN
                w_wrEn    = 1'b1;
                w_rdIssue = 1'b1;
                w_rdAddr  = ~w_addr;
`else
                w_wrEn    = ~r_phase;
                w_rdIssue = r_phase;
`endif
            end
        end
    end

    // Plain registered RAM with no reset so it maps onto EBR; the read sees pre-write contents.
    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            r_mem[w_wrAddr] <= w_data;
        end
        r_rdData <= r_mem[r_rdAddr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= FILL;
            r_fillPtr   <= '0;
            r_phase     <= 1'b0;
            r_rdPend    <= 1'b0;
            r_rdAddr    <= '0;
            r_rdValid   <= 1'b0;
            r_fillDone  <= 1'b0;
            r_signature <= {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            r_dummy     <= 1'b0;
        end else begin
            // The read pipeline drains regardless of enable.
            r_rdPend  <= w_rdIssue;
            r_rdValid <= r_rdPend;
            if (w_rdIssue) begin
                r_rdAddr <= w_rdAddr;
            end
            if (r_rdValid) begin
                r_signature <= {r_signature[DATA_WIDTH-2:0], r_signature[DATA_WIDTH-1]} ^ r_rdData;
            end
            r_dummy <= ^r_signature;
            if (enable) begin
                case (r_state)
                    FILL: begin
                        r_fillPtr <= r_fillPtr + 1'b1;
                        if (&r_fillPtr) begin
                            r_state    <= RUN;
                            r_fillDone <= 1'b1;
                        end
                    end
                    RUN: begin
`ifdef RAM_THRASH_DUAL_ISSUE_EN
                        r_phase <= 1'b0;
`else
                        r_phase <= ~r_phase;
`endif
                    end
                    default: r_state <= FILL;
                endcase
            end
        end
    end

    assign fill_done = r_fillDone;
    assign signature = r_signature;
    assign dummy     = r_dummy;

endmodule

// File: tb/tb_ram_thrash.sv
// Randomized self-checking bench for ram_thrash (ADDR_WIDTH=2) against a transaction-level model.
// Honours RAM_THRASH_DUAL_ISSUE_EN the same way the design does.
module tb_ram_thrash;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] dummyAddress;
    logic [15:0] dummyData;
    logic        fillDone;
    logic [15:0] signature;
    logic        dummy;

    int compared   = 0;
    int mismatched = 0;
    bit checkOn    = 1'b0;

    // Model state: RAM image, pending reads and the expected outputs.
    typedef struct {
        int          captureEdge;
        int          addr;
        logic [15:0] val;
    } readReq_t;

    readReq_t    pendQ[$];
    logic [15:0] mMem [4];
    logic [15:0] mSig;
    logic        mDummy;
    logic        mFillDone;
    bit          mFilling;
    int          mPtr;
    bit          mPhase;
    int          edgeNo = 0;

    ram_thrash #(.ADDR_WIDTH(2), .DATA_WIDTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .dummy_address (dummyAddress),
        .dummy_data    (dummyData),
        .fill_done     (fillDone),
        .signature     (signature),
        .dummy         (dummy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge given the inputs the DUT sampled on it.
    // A read issued on edge E captures RAM on edge E+1 (before that edge's write) and folds on E+2.
    task automatic modelStep(input logic r, input logic e, input logic [1:0] a, input logic [15:0] d);
        readReq_t keep[$];
        readReq_t q;
        edgeNo++;
        if (r) begin
            pendQ.delete();
            mSig      = 16'h0001;
            mDummy    = 1'b0;
            mFillDone = 1'b0;
            mFilling  = 1'b1;
            mPtr      = 0;
            mPhase    = 1'b0;
            return;
        end
        mDummy = ^mSig;
        foreach (pendQ[i]) begin
            q = pendQ[i];
            if (q.captureEdge == edgeNo) begin
                q.val = mMem[q.addr];
                keep.push_back(q);
            end else if (q.captureEdge + 1 == edgeNo) begin
                mSig = {mSig[14:0], mSig[15]} ^ q.val;
            end else begin
                keep.push_back(q);
            end
        end
        pendQ = keep;
        if (e) begin
            if (mFilling) begin
                mMem[mPtr] = d;
                if (mPtr == 3) begin
                    mFilling  = 1'b0;
                    mFillDone = 1'b1;
                    mPtr      = 0;
                end else begin
                    mPtr++;
                end
            end else begin
`ifdef RAM_THRASH_DUAL_ISSUE_EN
                mMem[a] = d;
                q.captureEdge = edgeNo + 1;
                q.addr        = 3 - a;
                q.val         = 16'h0;
                pendQ.push_back(q);
`else
                if (!mPhase) begin
                    mMem[a] = d;
                end else begin
                    q.captureEdge = edgeNo + 1;
                    q.addr        = a;
                    q.val         = 16'h0;
                    pendQ.push_back(q);
                end
                mPhase = ~mPhase;
`endif
            end
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then let the model follow the rising edge.
    task automatic applyStimulus(input logic r, input logic e, input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        reset        = r;
        enable       = e;
        dummyAddress = {$urandom_range(0, 16383), a};
        dummyData    = d;
        @(posedge clk);
        modelStep(r, e, a, d);
    endtask

    // Every falling edge the visible outputs must match the model.
    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("fill_done", {31'b0, fillDone}, {31'b0, mFillDone});
            checkOutput("signature", {16'b0, signature}, {16'b0, mSig});
            checkOutput("dummy", {31'b0, dummy}, {31'b0, mDummy});
        end
    end

    logic [15:0] fillVals [4];

    initial begin
        fillVals[0] = 16'h1111;
        fillVals[1] = 16'h2222;
        fillVals[2] = 16'h3333;
        fillVals[3] = 16'h4444;
        reset = 1'b1;
        enable = 1'b1;
        dummyAddress = 16'h0;
        dummyData = 16'h0;

        // Reset held with enable high: outputs sit at their reset values.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 2'd0, 16'hFFFF);
            checkOn = 1'b1;
            #1;
            checkOutput("rst_signature", {16'b0, signature}, 32'h0001);
            checkOutput("rst_fill_done", {31'b0, fillDone}, 32'h0);
            checkOutput("rst_dummy", {31'b0, dummy}, 32'h0);
        end

        // Fill with a gap of disabled cycles after two writes.
        applyStimulus(1'b0, 1'b1, 2'd3, fillVals[0]);
        applyStimulus(1'b0, 1'b1, 2'd3, fillVals[1]);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 2'd1, 16'hDEAD);
        #1;
        checkOutput("fill_ptr_held", {30'b0, dut.r_fillPtr}, 32'd2);
        checkOutput("fill_done_gap", {31'b0, fillDone}, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'd0, fillVals[2]);
        #1;
        checkOutput("fill_done_3rd", {31'b0, fillDone}, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'd0, fillVals[3]);
        #1;
        checkOutput("fill_done_4th", {31'b0, fillDone}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("mem[%0d]", i), {16'b0, dut.r_mem[i]}, {16'b0, fillVals[i]});
        end

`ifdef RAM_THRASH_DUAL_ISSUE_EN
        // One enabled cycle writes mem[0] and reads mem[3].
        applyStimulus(1'b0, 1'b1, 2'd0, 16'hBEEF);
        applyStimulus(1'b0, 1'b0, 2'd0, 16'h0);
        #1;
        checkOutput("dual_mem0", {16'b0, dut.r_mem[0]}, 32'hBEEF);
        checkOutput("dual_rd_data", {16'b0, dut.r_rdData}, 32'h4444);
        applyStimulus(1'b0, 1'b0, 2'd0, 16'h0);
        #1;
        checkOutput("dual_signature", {16'b0, signature}, 32'h4446);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 2'd0, 16'h0);
        applyStimulus(1'b0, 1'b1, 2'd1, 16'h5555);
`else
        // Write then read address 1, then drop enable while the read drains.
        applyStimulus(1'b0, 1'b1, 2'd1, 16'hAAAA);
        applyStimulus(1'b0, 1'b1, 2'd1, 16'h0);
        applyStimulus(1'b0, 1'b0, 2'd1, 16'h0);
        #1;
        checkOutput("sp_rd_data", {16'b0, dut.r_rdData}, 32'hAAAA);
        applyStimulus(1'b0, 1'b0, 2'd1, 16'h0);
        #1;
        checkOutput("sp_signature", {16'b0, signature}, 32'hAAA8);
        applyStimulus(1'b0, 1'b0, 2'd1, 16'h0);
        #1;
        checkOutput("sp_dummy", {31'b0, dummy}, 32'h1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 2'd1, 16'h0);
        #1;
        checkOutput("sp_no_new_access", {31'b0, dut.r_rdValid}, 32'h0);
        checkOutput("sp_signature_hold", {16'b0, signature}, 32'hAAA8);
        applyStimulus(1'b0, 1'b1, 2'd2, 16'h5555);
        applyStimulus(1'b0, 1'b1, 2'd2, 16'h0);
`endif
        // Reset on the edge the read data comes back.
        applyStimulus(1'b1, 1'b1, 2'd0, 16'h0);
        #1;
        checkOutput("midrun_signature", {16'b0, signature}, 32'h0001);
        checkOutput("midrun_rd_valid", {31'b0, dut.r_rdValid}, 32'h0);
        checkOutput("midrun_fill_done", {31'b0, fillDone}, 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 2'(i), fillVals[i]);
        #1;
        checkOutput("refill_3rd", {31'b0, fillDone}, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'd0, fillVals[3]);
        #1;
        checkOutput("refill_4th", {31'b0, fillDone}, 32'h1);

        // Random traffic with occasional resets; the falling-edge compare checks every cycle.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
                          2'($urandom_range(0, 3)),
                          16'($urandom));
        end
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ram_thrash.md
Name: ram_thrash

Overview:
- Downstream consumer of the pseudorandom flip-flop generator in the power stress tops.
- Takes the generator's dummy_address/dummy_data buses and exercises block RAM continuously, so EBR toggling adds to the power load.
- Folds every read word into a rotating-XOR signature and reduces it to one bit. That bit drives an LED, which stops synthesis from pruning the RAM.
- Instantiated once per stress top, between pseudorandom_ff and the led outputs.

Parameters:
- ADDR_WIDTH, 10, RAM address bits; DEPTH = 2**ADDR_WIDTH words; must be <= 16.
- DATA_WIDTH, 16, RAM word width and signature width; must be <= 16.

Ports:
- clk  input  1  system clock, single domain.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  advance the FSM; when low, no new RAM accesses are issued.
- dummy_address  input  16  generator address bus; only bits [ADDR_WIDTH-1:0] are used.
- dummy_data  input  16  generator data bus; only bits [DATA_WIDTH-1:0] are used.
- fill_done  output  1  high once every RAM word has been written since reset.
- signature  output  DATA_WIDTH  running read signature.
- dummy  output  1  registered XOR-reduction of signature.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset); it is sampled only on the rising edge of clk.
- Reset values: state=FILL, fill_ptr=0, phase=0, rd_valid=0, fill_done=0, signature=1 (LSB set), dummy=0. RAM contents are not cleared; the bench must not depend on them.
- States: FILL -> RUN. There is no other exit from RUN except reset.
- FILL, on each cycle with enable=1:
  - Write mem[fill_ptr] = dummy_data; then fill_ptr++.
  - The edge that writes address DEPTH-1 sets fill_done=1 and moves to RUN. fill_ptr then wraps to 0 and is unused afterwards.
  - enable=0 holds fill_ptr; no write occurs.
- RUN, single-port (default):
  - phase toggles on each cycle with enable=1.
  - phase=0: write mem[addr] = data.
  - phase=1: read mem[addr], where addr = dummy_address[ADDR_WIDTH-1:0].
  - The first RUN cycle is always phase=0 (write).
- Read pipeline for a read issued on edge N:
  - rd_data and rd_valid are valid after edge N+1.
  - On edge N+2: signature <= rotl1(signature) ^ rd_data.
  - On edge N+3: dummy <= ^signature.
- rd_valid is not gated by enable. A read already issued completes even if enable drops.
- The signature updates only when rd_valid=1; otherwise it holds.
- Read-during-write to the same address on the same edge returns the old data (read-before-write).
- Reset asserted mid-FILL or mid-RUN: on that edge the block returns to the reset values above. Any in-flight read is discarded (rd_valid=0).
- fill_done stays high until reset.

Optional Feature:
- Macro: RAM_THRASH_DUAL_ISSUE_EN.
- Defined: in RUN, every enabled cycle both writes mem[addr] = data and reads mem[~addr] (bitwise-inverted address). phase is unused and held at 0. This doubles EBR activity. Read latency and signature rules are unchanged.
- Undefined: alternating write/read as described above.
- FILL behaviour is identical in both builds.

Test Plan:
- Reset check: hold reset high for 3 cycles with enable=1 -> fill_done=0, signature=0x0001, dummy=0, and no change while reset is high.
- FILL, ADDR_WIDTH=2: release reset and drive data 0x1111, 0x2222, 0x3333, 0x4444 on 4 enabled cycles -> fill_done rises on the 4th edge. A backdoor read of mem[0..3] returns exactly those values.
- RUN, single-port, ADDR_WIDTH=2, after fill:
  - Cycle A: addr=1, data=0xAAAA (write). Cycle B: addr=1 (read).
  - Required: rd_data=0xAAAA one edge after B; signature=0xAAA8 two edges after B; dummy=1 three edges after B.
- Enable gating: in FILL, drop enable for 5 cycles after 2 writes -> fill_ptr stays at 2 and no writes occur. Drop enable the cycle after a RUN read issue -> that read still updates the signature, and no further accesses are issued.
- Reset mid-RUN: assert reset on the edge the read data returns -> signature=0x0001, rd_valid=0, state=FILL, fill_done=0. A refill of 4 writes is required before fill_done rises again.
- With RAM_THRASH_DUAL_ISSUE_EN, ADDR_WIDTH=2, after fill with 0x1111..0x4444:
  - Drive addr=0, data=0xBEEF for one cycle.
  - Required: mem[0]=0xBEEF and a read of mem[3]=0x4444. Signature becomes rotl1(0x0001)^0x4444 = 0x4446 two edges later.
